// File: rtl/ingress_frame_arbiter_if.sv
// Bus bundle for ingress_frame_arbiter: Avalon-MM register port, upstream AXI-Stream sources
// and the single egress stream toward frame_receptor.
interface ingress_frame_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic [7:0]                      writedata;
    logic                            write;
    logic                            chipselect;
    logic [7:0]                      address;
    logic                            read;
    logic [7:0]                      readdata;

    logic [NUM_PORTS*DATA_WIDTH-1:0] src_tdata;
    logic [NUM_PORTS-1:0]            src_tvalid;
    logic [NUM_PORTS-1:0]            src_tready;
    logic [NUM_PORTS-1:0]            src_tlast;

    logic [DATA_WIDTH-1:0]           egress_port_tdata;
    logic                            egress_port_tvalid;
    logic                            egress_port_tready;
    logic                            egress_port_tlast;

    // Arbiter side.
    modport slave (
        input  writedata, write, chipselect, address, read,
        output readdata,
        input  src_tdata, src_tvalid, src_tlast,
        output src_tready,
        output egress_port_tdata, egress_port_tvalid, egress_port_tlast,
        input  egress_port_tready
    );

    // Host / sources / sink side.
    modport master (
        output writedata, write, chipselect, address, read,
        input  readdata,
        output src_tdata, src_tvalid, src_tlast,
        input  src_tready,
        input  egress_port_tdata, egress_port_tvalid, egress_port_tlast,
        output egress_port_tready
    );
endinterface

// File: rtl/ingress_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one AXI-Stream egress between NUM_PORTS sources,
// with an Avalon-MM register port for the enable mask, grant status and per-port frame counters.
module ingress_frame_arbiter #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input logic                    clk,
    input logic                    reset,
    ingress_frame_arbiter_if.slave bus
);
    localparam int unsigned IDX_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [7:0]  MASK_VALID    = 8'((1 << NUM_PORTS) - 1);
    localparam logic [7:0]  ADDR_MASK     = 8'd0;
    localparam logic [7:0]  ADDR_STATUS   = 8'd1;
    localparam logic [7:0]  ADDR_CNT_BASE = 8'd2;
    localparam logic [7:0]  ADDR_CLEAR    = 8'd16;

    typedef enum logic {StIdle, StActive} state_e;

    state_e           r_state;
    logic [IDX_W-1:0] r_gnt;
    logic [IDX_W-1:0] r_last_grant;
    logic [7:0]       r_mask;
    logic [7:0]       r_cnt [NUM_PORTS];
    logic [7:0]       r_readdata;

    logic [NUM_PORTS-1:0]  w_req;
    logic [IDX_W-1:0]      w_pick;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_active;
    logic                  w_gnt_valid;
    logic                  w_gnt_last;
    logic                  w_frame_end;
    logic                  w_reg_wr;
    logic                  w_reg_rd;
    logic                  w_clear;
    logic [2:0]            w_gnt3;
    logic [7:0]            w_rdata;
    logic [DATA_WIDTH-1:0] w_src_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_src_tready;
    logic [DATA_WIDTH-1:0] w_eg_tdata;
    logic                  w_eg_tvalid;
    logic                  w_eg_tlast;

    assign w_active    = (r_state == StActive);
    assign w_req       = bus.src_tvalid & r_mask[NUM_PORTS-1:0];
    assign w_gnt_valid = bus.src_tvalid[r_gnt];
    assign w_gnt_last  = bus.src_tlast[r_gnt];
    assign w_frame_end = w_active & w_gnt_valid & bus.egress_port_tready & w_gnt_last;
    assign w_reg_wr    = bus.chipselect & bus.write;
    assign w_reg_rd    = bus.chipselect & bus.read;
    assign w_clear     = w_reg_wr && (bus.address == ADDR_CLEAR);
    assign w_gnt3      = w_active ? 3'(r_gnt) : 3'b000;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_src_data[i] = bus.src_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Walk offsets from the far end down so the nearest requester after last_grant wins.
    always_comb begin
        w_pick = r_last_grant;
        w_idx  = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_idx = IDX_W'((int'(r_last_grant) + k) % NUM_PORTS);
            if (w_req[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_src_tready = '0;
        w_eg_tvalid  = 1'b0;
        w_eg_tlast   = 1'b0;
        w_eg_tdata   = '0;
        if (w_active) begin
            w_src_tready[r_gnt] = bus.egress_port_tready;
            w_eg_tvalid         = w_gnt_valid;
            w_eg_tlast          = w_gnt_last;
            if (w_gnt_valid) begin
                w_eg_tdata = w_src_data[r_gnt];
            end
        end
    end

    always_comb begin
        w_rdata = 8'd0;
        if (bus.address == ADDR_MASK) begin
            w_rdata = r_mask;
        end else if (bus.address == ADDR_STATUS) begin
            w_rdata = {w_active, 4'b0000, w_gnt3};
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.address == ADDR_CNT_BASE + 8'(i)) begin
                w_rdata = r_cnt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_gnt        <= '0;
            r_last_grant <= IDX_W'(NUM_PORTS - 1);
            r_mask       <= MASK_VALID;
            r_readdata   <= 8'd0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_cnt[i] <= 8'd0;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    if (|w_req) begin
                        r_gnt   <= w_pick;
                        r_state <= StActive;
                    end
                end
                StActive: begin
                    // Return to idle for one bubble cycle between frames.
                    if (w_frame_end) begin
                        r_last_grant <= r_gnt;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase

            if (w_reg_wr && (bus.address == ADDR_MASK)) begin
                r_mask <= bus.writedata & MASK_VALID;
            end

            // A clear in the same cycle as a frame end wins over the increment.
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_clear) begin
                    r_cnt[i] <= 8'd0;
                end else if (w_frame_end && (r_gnt == IDX_W'(i))) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end

            r_readdata <= w_reg_rd ? w_rdata : 8'd0;
        end
    end

    assign bus.readdata           = r_readdata;
    assign bus.src_tready         = w_src_tready;
    assign bus.egress_port_tdata  = w_eg_tdata;
    assign bus.egress_port_tvalid = w_eg_tvalid;
    assign bus.egress_port_tlast  = w_eg_tlast;
endmodule

// File: tb/tb_ingress_frame_arbiter.sv
// Self-checking bench for ingress_frame_arbiter: a per-cycle vector table for passthrough,
// backpressure and round-robin basics, then hand sequences for masking, counters and reset.
module tb_ingress_frame_arbiter;
    localparam int NP = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ingress_frame_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

    ingress_frame_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Port i receives tdata = d ^ (i << 12), so the egress value identifies the source.
    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic        rdy;
        logic [15:0] d;
        logic        ev;
        logic        el;
        logic [15:0] ed;
        logic [3:0]  srdy;
    } vec_t;

    vec_t vecs [15];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_data(input logic [15:0] d);
        for (int i = 0; i < NP; i++) begin
            bus.src_tdata[i*DW +: DW] = d ^ (16'(i) << 12);
        end
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = addr;
        bus.writedata  = data;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic reg_read(input string name, input logic [7:0] addr, input logic [7:0] exp);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = addr;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        #1;
        check(name, 32'(bus.readdata), 32'(exp));
    endtask

    // Single-beat frames on port 3 until n tlast handshakes have been seen.
    task automatic port3_frames(input string name, input int n);
        int done = 0;
        int cyc  = 0;
        bus.src_tvalid = 4'b1000;
        bus.src_tlast  = 4'b1000;
        while (done < n && cyc < 4 * n + 10) begin
            @(negedge clk);
            #1;
            cyc++;
            if (bus.egress_port_tvalid && bus.egress_port_tready && bus.src_tready[3]) begin
                done++;
            end
        end
        @(negedge clk);
        bus.src_tvalid = 4'b0000;
        bus.src_tlast  = 4'b0000;
        if (done != n) begin
            check(name, 32'(done), 32'(n));
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   beat [NP];
        int   order[$];
        int   exp_order[6] = '{0, 2, 3, 0, 2, 3};
        int   gap;
        int   frames;
        int   cyc;
        int   g;
        bit   seen_first;
        logic [15:0] exp_d;

        // Per-cycle table: idle, port 1 frame with backpressure, then round-robin order.
        vecs[0]  = '{4'b0000, 4'b0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0000};
        vecs[1]  = '{4'b0010, 4'b0000, 1'b1, 16'h0111, 1'b0, 1'b0, 16'h0000, 4'b0000};
        vecs[2]  = '{4'b0010, 4'b0000, 1'b1, 16'h0111, 1'b1, 1'b0, 16'h1111, 4'b0010};
        vecs[3]  = '{4'b0010, 4'b0000, 1'b0, 16'h3222, 1'b1, 1'b0, 16'h2222, 4'b0000};
        vecs[4]  = '{4'b0010, 4'b0000, 1'b1, 16'h3222, 1'b1, 1'b0, 16'h2222, 4'b0010};
        vecs[5]  = '{4'b0010, 4'b0000, 1'b0, 16'h2333, 1'b1, 1'b0, 16'h3333, 4'b0000};
        vecs[6]  = '{4'b0010, 4'b0000, 1'b1, 16'h2333, 1'b1, 1'b0, 16'h3333, 4'b0010};
        vecs[7]  = '{4'b0010, 4'b0010, 1'b1, 16'h5444, 1'b1, 1'b1, 16'h4444, 4'b0010};
        vecs[8]  = '{4'b1011, 4'b0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0000};
        vecs[9]  = '{4'b1011, 4'b1000, 1'b1, 16'h0AAA, 1'b1, 1'b1, 16'h3AAA, 4'b1000};
        vecs[10] = '{4'b0011, 4'b0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0000};
        vecs[11] = '{4'b0011, 4'b0001, 1'b1, 16'h0BBB, 1'b1, 1'b1, 16'h0BBB, 4'b0001};
        vecs[12] = '{4'b0010, 4'b0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0000};
        vecs[13] = '{4'b0010, 4'b0010, 1'b1, 16'h0CCC, 1'b1, 1'b1, 16'h1CCC, 4'b0010};
        vecs[14] = '{4'b0000, 4'b0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0000};

        bus.writedata          = '0;
        bus.write              = 1'b0;
        bus.chipselect         = 1'b0;
        bus.address            = '0;
        bus.read               = 1'b0;
        bus.src_tdata          = '0;
        bus.src_tvalid         = '0;
        bus.src_tlast          = '0;
        bus.egress_port_tready = 1'b1;
        reset                  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset readdata", 32'(bus.readdata), 32'h0);
        check("reset egress tvalid", 32'(bus.egress_port_tvalid), 32'h0);
        check("reset src_tready", 32'(bus.src_tready), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.src_tvalid         = vecs[i].v;
            bus.src_tlast          = vecs[i].l;
            bus.egress_port_tready = vecs[i].rdy;
            set_data(vecs[i].d);
            #1;
            check($sformatf("vec%0d tvalid", i), 32'(bus.egress_port_tvalid), 32'(vecs[i].ev));
            check($sformatf("vec%0d tlast", i), 32'(bus.egress_port_tlast), 32'(vecs[i].el));
            check($sformatf("vec%0d tdata", i), 32'(bus.egress_port_tdata), 32'(vecs[i].ed));
            check($sformatf("vec%0d src_tready", i), 32'(bus.src_tready), 32'(vecs[i].srdy));
        end
        bus.egress_port_tready = 1'b1;

        // Status mid-frame on port 1.
        @(negedge clk);
        bus.src_tvalid = 4'b0010;
        bus.src_tlast  = 4'b0000;
        reg_read("status active p1", 8'd1, 8'h81);
        @(negedge clk);
        bus.src_tlast = 4'b0010;
        @(negedge clk);
        bus.src_tvalid = 4'b0000;
        bus.src_tlast  = 4'b0000;

        reg_read("mask reset value", 8'd0, 8'h0F);
        @(negedge clk);
        #1;
        check("readdata zero w/o read", 32'(bus.readdata), 32'h0);
        reg_read("status idle", 8'd1, 8'h00);
        reg_read("cnt0 table", 8'd2, 8'd1);
        reg_read("cnt1 table", 8'd3, 8'd3);
        reg_read("cnt2 table", 8'd4, 8'd0);
        reg_read("cnt3 table", 8'd5, 8'd1);
        reg_read("unmapped read", 8'd9, 8'h00);
        reg_write(8'd0, 8'hFF);
        reg_read("mask upper bits", 8'd0, 8'h0F);

        // Round robin: ports 0, 2, 3 streaming 2-beat frames from a fresh reset.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < NP; p++) beat[p] = 0;
        gap        = 0;
        frames     = 0;
        cyc        = 0;
        seen_first = 1'b0;
        bus.src_tvalid = 4'b1101;
        while (frames < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            for (int p = 0; p < NP; p++) begin
                bus.src_tlast[p]          = (beat[p] == 1);
                bus.src_tdata[p*DW +: DW] = {4'hA, 4'(p), 4'(beat[p]), 4'(frames)};
            end
            #1;
            if (bus.egress_port_tvalid && bus.egress_port_tready) begin
                check("rr onehot ready", 32'($countones(bus.src_tready)), 32'd1);
                g = 0;
                for (int q = 0; q < NP; q++) if (bus.src_tready[q]) g = q;
                exp_d = {4'hA, 4'(g), 4'(beat[g]), 4'(frames)};
                check("rr tdata", 32'(bus.egress_port_tdata), 32'(exp_d));
                if (beat[g] == 0) begin
                    if (seen_first) check("rr bubble", 32'(gap), 32'd1);
                    seen_first = 1'b1;
                    order.push_back(g);
                end
                if (bus.egress_port_tlast) begin
                    frames++;
                    gap = 0;
                end
                beat[g] = beat[g] ^ 1;
            end else begin
                gap++;
            end
        end
        @(negedge clk);
        bus.src_tvalid = 4'b0000;
        bus.src_tlast  = 4'b0000;
        check("rr frame count", 32'(order.size()), 32'd6);
        for (int k = 0; k < 6 && k < order.size(); k++) begin
            check($sformatf("rr order%0d", k), 32'(order[k]), 32'(exp_order[k]));
        end
        reg_read("rr cnt0", 8'd2, 8'd2);
        reg_read("rr cnt1", 8'd3, 8'd0);
        reg_read("rr cnt2", 8'd4, 8'd2);
        reg_read("rr cnt3", 8'd5, 8'd2);

        // Mask change mid-frame: port 0 finishes, then only port 2 is granted.
        @(negedge clk);
        bus.src_tvalid = 4'b0111;
        bus.src_tlast  = 4'b0000;
        set_data(16'h0100);
        #1;
        check("mask pre idle", 32'(bus.src_tready), 32'h0);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 8'd0;
        bus.writedata  = 8'h04;
        #1;
        check("mask p0 granted", 32'(bus.src_tready), 32'b0001);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        #1;
        check("mask p0 lock", 32'(bus.src_tready), 32'b0001);
        check("mask p0 data", 32'(bus.egress_port_tdata), 32'h0100);
        bus.src_tlast = 4'b0001;
        @(negedge clk);
        bus.src_tlast = 4'b0000;
        #1;
        check("mask bubble", 32'(bus.egress_port_tvalid), 32'h0);
        @(negedge clk);
        #1;
        check("mask only p2", 32'(bus.src_tready), 32'b0100);
        check("mask p2 data", 32'(bus.egress_port_tdata), 32'h2100);
        bus.src_tlast = 4'b0100;
        @(negedge clk);
        bus.src_tlast = 4'b0000;
        @(negedge clk);
        #1;
        check("mask p2 again", 32'(bus.src_tready), 32'b0100);
        bus.src_tlast = 4'b0100;
        @(negedge clk);
        bus.src_tlast  = 4'b0000;
        bus.src_tvalid = 4'b0011;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 8'd0;
        bus.writedata  = 8'h00;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.src_tvalid = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("mask0 src_tready%0d", k), 32'(bus.src_tready), 32'h0);
            check($sformatf("mask0 tvalid%0d", k), 32'(bus.egress_port_tvalid), 32'h0);
        end
        reg_read("mask0 status", 8'd1, 8'h00);
        reg_read("mask0 readback", 8'd0, 8'h00);
        bus.src_tvalid = 4'b0000;

        // Counter wrap and clear-wins-over-increment.
        reg_write(8'd16, 8'h00);
        reg_read("clear cnt0", 8'd2, 8'd0);
        reg_write(8'd0, 8'h08);
        port3_frames("p3 255 frames", 255);
        reg_read("cnt3 255", 8'd5, 8'd255);
        port3_frames("p3 wrap frame", 1);
        reg_read("cnt3 wrap", 8'd5, 8'd0);
        port3_frames("p3 3 frames", 3);
        reg_read("cnt3 three", 8'd5, 8'd3);
        @(negedge clk);
        bus.src_tvalid = 4'b1000;
        bus.src_tlast  = 4'b1000;
        @(negedge clk);
        #1;
        check("clr coincide active", 32'(bus.src_tready), 32'b1000);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 8'd16;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.src_tvalid = 4'b0000;
        bus.src_tlast  = 4'b0000;
        reg_read("clear wins", 8'd5, 8'd0);

        // Reset in the middle of a port 1 frame.
        reg_write(8'd0, 8'h0F);
        @(negedge clk);
        bus.src_tvalid = 4'b0010;
        bus.src_tlast  = 4'b0010;
        @(negedge clk);
        #1;
        check("rst first frame", 32'(bus.src_tready), 32'b0010);
        @(negedge clk);
        bus.src_tlast = 4'b0000;
        @(negedge clk);
        #1;
        check("rst beat1", 32'(bus.src_tready), 32'b0010);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst async tvalid", 32'(bus.egress_port_tvalid), 32'h0);
        check("rst async src_tready", 32'(bus.src_tready), 32'h0);
        @(negedge clk);
        reset          = 1'b0;
        bus.src_tvalid = 4'b0000;
        reg_read("rst mask", 8'd0, 8'h0F);
        reg_read("rst cnt1", 8'd3, 8'd0);
        reg_read("rst status", 8'd1, 8'h00);
        @(negedge clk);
        bus.src_tvalid = 4'b0011;
        @(negedge clk);
        #1;
        check("rst p0 wins", 32'(bus.src_tready), 32'b0001);
        bus.src_tvalid = 4'b0000;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ingress_frame_arbiter.md
Name: ingress_frame_arbiter

Overview:
- Shares one frame_receptor ingress stream between NUM_PORTS upstream AXI-Stream sources.
- Grants at frame granularity: once granted, a source holds the egress until its tlast beat completes.
- Selects the next source round-robin, filtered by a software enable mask.
- Exposes an 8-bit Avalon-MM slave for the mask, grant status and per-port frame counters. Sits directly in front of frame_receptor's ingress_port.

Parameters:
- NUM_PORTS, 4, number of upstream sources; legal range 2..8.
- DATA_WIDTH, 16, tdata width per beat; matches frame_receptor ingress.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- writedata  in  8  Avalon write data
- write  in  1  Avalon write strobe
- chipselect  in  1  Avalon chip select
- address  in  8  Avalon register address
- read  in  1  Avalon read strobe
- readdata  out  8  Avalon read data, registered
- src_tdata  in  NUM_PORTS*DATA_WIDTH  source data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- src_tvalid  in  NUM_PORTS  per-source valid
- src_tready  out  NUM_PORTS  per-source ready
- src_tlast  in  NUM_PORTS  per-source end of frame
- egress_port_tdata  out  DATA_WIDTH  to frame_receptor ingress_port_tdata
- egress_port_tvalid  out  1  to ingress_port_tvalid
- egress_port_tready  in  1  from ingress_port_tready
- egress_port_tlast  out  1  to ingress_port_tlast

Behaviour:
- Reset: asynchronous, active-high. All state clears immediately, including mid-frame.
  - FSM goes to IDLE; enable mask becomes all ones for bits < NUM_PORTS, zero above.
  - last_grant = NUM_PORTS-1, so port 0 has first priority.
  - Frame counters = 0; readdata = 0; src_tready = 0; egress_port_tvalid/tlast = 0; egress_port_tdata = 0.
- FSM states: IDLE, ACTIVE. Registered grant index gnt.
- IDLE:
  - req = src_tvalid & enable_mask.
  - If req != 0: gnt <= first set bit of req searching from last_grant+1 upward, wrapping modulo NUM_PORTS; go to ACTIVE.
  - Otherwise stay in IDLE.
  - All src_tready = 0 and egress_port_tvalid = 0 in IDLE.
- ACTIVE: combinational passthrough of the granted source, zero added latency.
  - egress_port_tdata/tvalid/tlast = src_*[gnt].
  - src_tready[gnt] = egress_port_tready; all other src_tready = 0.
  - egress_port_tdata = 0 whenever egress_port_tvalid = 0.
- Frame end: on src_tvalid[gnt] & egress_port_tready & src_tlast[gnt]:
  - last_grant <= gnt;
  - frame_cnt[gnt] increments, 8-bit, wrapping 255->0;
  - FSM returns to IDLE.
  - Exactly one bubble cycle separates frames. The arbiter therefore never occupies the egress on the cycle after tlast, consistent with frame_receptor's inter-frame hold.
- Grant lock: clearing a port's enable bit while that port is in ACTIVE does not revoke the grant; the frame completes. The change affects arbitration from the next IDLE onward.
- A source deasserting tvalid mid-frame stalls the egress. The grant is held indefinitely; no timeout.
- Enable mask = 0: the arbiter stays in IDLE and all src_tready = 0.
- Register map (write takes effect at the clock edge; read data appears on readdata one cycle after chipselect&read, and is 0 in any cycle without a read):
  - 0 RW: enable mask; bits >= NUM_PORTS are written as 0 and read as 0.
  - 1 R: status = {active, 4'b0, gnt[2:0]}; gnt reads 0 when not active.
  - 2..2+NUM_PORTS-1 R: frame_cnt[address-2].
  - 16 W: any write clears all frame counters. If it coincides with a frame-end increment, the clear wins and the counter reads 0.
  - Other addresses: writes ignored, reads return 0.

Test Plan:
- Single source: after reset, port 1 sends a 4-beat frame of 0x1111..0x4444 with tlast on beat 4 and egress_tready=1 -> grant on the cycle after tvalid rises; egress shows the 4 beats unchanged with tlast on the 4th; status reads 0x81 during the frame; frame_cnt[1]=1.
- Round robin: ports 0, 2 and 3 hold tvalid continuously with 2-beat frames -> grant order 0,2,3,0,2,3; exactly one idle cycle between frames; counters read 2,0,2,2 after 6 frames.
- Backpressure: egress_tready toggles 1,0,1,0 mid-frame -> src_tready[gnt] mirrors it; beats are neither duplicated nor dropped; non-granted src_tready stays 0.
- Mask: write 0x04 to address 0 while port 0 is mid-frame -> port 0 completes its frame; afterwards only port 2 is granted even though ports 0 and 1 are valid. Write 0x00 -> no grants; all src_tready=0.
- Counters and clear: 256 frames on port 3 -> frame_cnt[3] wraps to 0. Write to address 16 in the same cycle as a port 3 tlast handshake -> frame_cnt[3] reads 0.
- Reset mid-frame: assert reset during beat 2 of a port 1 frame -> egress_tvalid and src_tready drop immediately (asynchronously); after release the mask reads 0x0F, the counters read 0, and port 0 wins when ports 0 and 1 request together.
